// File: rtl/evac_pkg.sv
// evac_pkg: shared widths, dispatcher state encoding and mission-time defaults
package evac_pkg;
    localparam int ZONE_W = 8;
    localparam int PRIO_W = 2;
    localparam int DEF_MISSION_BASE = 16;
    localparam int DEF_MISSION_STEP = 8;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;
    function automatic int mission_cycles(input int base, input int step, input logic [PRIO_W-1:0] prio);
        return base + int'(prio) * step;
    endfunction
endpackage

// File: rtl/evac_team_timer.sv
// evac_team_timer: per-team mission countdown, busy while nonzero
module evac_team_timer #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TIME_W-1:0] load_val,
    input  logic              recall,
    output logic              busy
);
    logic [TIME_W-1:0] t;
    always_ff @(posedge clk) begin
        if (rst) t <= '0;
        else if (load) t <= load_val;
        else if (recall) t <= '0;
        else if (t != '0) t <= t - 1'b1;
    end
    assign busy = t != '0;
endmodule

// File: rtl/evac_dispatcher.sv
// evac_dispatcher: pops queue entries and assigns them to the lowest free rescue team
module evac_dispatcher
    import evac_pkg::*;
#(
    parameter int NUM_TEAMS    = 4,
    parameter int TEAM_W       = 2,
    parameter int TIME_W       = 8,
    parameter int MISSION_BASE = DEF_MISSION_BASE,
    parameter int MISSION_STEP = DEF_MISSION_STEP
) (
    input  logic                 Main_Clock,
    input  logic                 Reset,
    input  logic                 Empty,
    input  logic [ZONE_W-1:0]    Output_Zone,
    input  logic [PRIO_W-1:0]    Output_Priority,
    input  logic                 Hold,
    input  logic [NUM_TEAMS-1:0] Team_Recall,
    output logic                 Serve,
    output logic                 Dispatch_Valid,
    output logic [ZONE_W-1:0]    Dispatch_Zone,
    output logic [PRIO_W-1:0]    Dispatch_Priority,
    output logic [TEAM_W-1:0]    Dispatch_Team,
    output logic [NUM_TEAMS-1:0] Team_Busy,
    output logic [15:0]          Dispatch_Count
);
    if (NUM_TEAMS < 1 || NUM_TEAMS > 8 || (1 << TEAM_W) < NUM_TEAMS ||
        MISSION_BASE + 3 * MISSION_STEP > (1 << TIME_W) - 1) begin : g_bad_params
        $error("evac_dispatcher: invalid parameter combination");
    end
    state_t            state;
    logic [TEAM_W-1:0] free_team;
    logic [TIME_W-1:0] load_val;
    assign load_val = TIME_W'(mission_cycles(MISSION_BASE, MISSION_STEP, Output_Priority));
    always_comb begin
        free_team = '0;
        for (int i = NUM_TEAMS - 1; i >= 0; i--) if (!Team_Busy[i]) free_team = TEAM_W'(i);
    end
    for (genvar i = 0; i < NUM_TEAMS; i++) begin : g_team
        evac_team_timer #(.TIME_W(TIME_W)) u_timer (
            .clk      (Main_Clock),
            .rst      (Reset),
            .load     (state == FETCH && free_team == TEAM_W'(i)),
            .load_val (load_val),
            .recall   (Team_Recall[i]),
            .busy     (Team_Busy[i])
        );
    end
    // Serve/Dispatch_Valid are registered so each is high exactly for its state
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            state             <= IDLE;
            Serve             <= 1'b0;
            Dispatch_Valid    <= 1'b0;
            Dispatch_Zone     <= '0;
            Dispatch_Priority <= '0;
            Dispatch_Team     <= '0;
            Dispatch_Count    <= '0;
        end else begin
            Serve          <= 1'b0;
            Dispatch_Valid <= 1'b0;
            case (state)
                IDLE: if (!Empty && !Hold && !(&Team_Busy)) begin
                    state <= FETCH;
                    Serve <= 1'b1;
                end
                FETCH: begin
                    state             <= ISSUE;
                    Dispatch_Valid    <= 1'b1;
                    Dispatch_Zone     <= Output_Zone;
                    Dispatch_Priority <= Output_Priority;
                    Dispatch_Team     <= free_team;
                    Dispatch_Count    <= (&Dispatch_Count) ? Dispatch_Count : Dispatch_Count + 16'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_evac_dispatcher.sv
// tb_evac_dispatcher: directed scenarios plus random traffic against a cycle-level reference model
module tb_evac_dispatcher;
    localparam int NT = 4;
    logic          Main_Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Empty = 1'b1;
    logic          Hold = 1'b0;
    logic [7:0]    Output_Zone = '0;
    logic [1:0]    Output_Priority = '0;
    logic [NT-1:0] Team_Recall = '0;
    logic          Serve, Dispatch_Valid;
    logic [7:0]    Dispatch_Zone;
    logic [1:0]    Dispatch_Priority;
    logic [1:0]    Dispatch_Team;
    logic [NT-1:0] Team_Busy;
    logic [15:0]   Dispatch_Count;

    evac_dispatcher dut (
        .Main_Clock        (Main_Clock),
        .Reset             (Reset),
        .Empty             (Empty),
        .Output_Zone       (Output_Zone),
        .Output_Priority   (Output_Priority),
        .Hold              (Hold),
        .Team_Recall       (Team_Recall),
        .Serve             (Serve),
        .Dispatch_Valid    (Dispatch_Valid),
        .Dispatch_Zone     (Dispatch_Zone),
        .Dispatch_Priority (Dispatch_Priority),
        .Dispatch_Team     (Dispatch_Team),
        .Team_Busy         (Team_Busy),
        .Dispatch_Count    (Dispatch_Count)
    );

    always #5 Main_Clock = ~Main_Clock;

    typedef struct {
        logic [7:0] z;
        logic [1:0] p;
    } ent_t;
    ent_t q[$];
    bit   pop;
    int   cyc_n;
    int   checks, errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining mission cycles per team, a dispatch occupies 3 cycles
    int         m_rem[NT];
    int         nrem[NT];
    int         ft;
    bit         go;
    bit         m_serve, m_valid;
    int         m_phase;
    logic [7:0] m_zone;
    logic [1:0] m_prio;
    int         m_team;
    int         m_count;

    always_comb begin
        ft = -1;
        for (int i = NT - 1; i >= 0; i--) if (m_rem[i] == 0) ft = i;
        for (int i = 0; i < NT; i++) nrem[i] = Team_Recall[i] ? 0 : (m_rem[i] > 0 ? m_rem[i] - 1 : 0);
        if (m_serve && ft >= 0) nrem[ft] = 16 + 8 * int'(Output_Priority);
        go = m_phase == 0 && !Empty && !Hold && ft >= 0;
    end

    always @(posedge Main_Clock) begin
        if (Reset) begin
            for (int i = 0; i < NT; i++) m_rem[i] <= 0;
            m_serve <= 0;
            m_valid <= 0;
            m_phase <= 0;
            m_zone  <= 0;
            m_prio  <= 0;
            m_team  <= 0;
            m_count <= 0;
        end else begin
            for (int i = 0; i < NT; i++) m_rem[i] <= nrem[i];
            m_serve <= go;
            m_valid <= m_serve;
            m_phase <= go ? 2 : (m_phase > 0 ? m_phase - 1 : 0);
            if (m_serve) begin
                m_zone  <= Output_Zone;
                m_prio  <= Output_Priority;
                m_team  <= ft;
                m_count <= m_count < 65535 ? m_count + 1 : m_count;
            end
        end
    end

    function automatic logic [NT-1:0] exp_busy();
        logic [NT-1:0] b;
        for (int i = 0; i < NT; i++) b[i] = m_rem[i] != 0;
        return b;
    endfunction

    always @(negedge Main_Clock) begin
        check("serve", 32'(Serve), 32'(m_serve));
        check("valid", 32'(Dispatch_Valid), 32'(m_valid));
        check("zone", 32'(Dispatch_Zone), 32'(m_zone));
        check("prio", 32'(Dispatch_Priority), 32'(m_prio));
        check("team", 32'(Dispatch_Team), 32'(m_team));
        check("busy", 32'(Team_Busy), 32'(exp_busy()));
        check("count", 32'(Dispatch_Count), 32'(m_count));
    end

    task automatic drive();
        Empty = q.size() == 0;
        if (q.size() > 0) begin
            Output_Zone     = q[0].z;
            Output_Priority = q[0].p;
        end
    endtask

    task automatic cyc();
        @(negedge Main_Clock);
        cyc_n++;
        if (pop && q.size() > 0) q.delete(0);
        pop = Serve;
        drive();
    endtask

    task automatic push(input logic [7:0] z, input logic [1:0] p);
        ent_t e;
        e.z = z;
        e.p = p;
        q.push_back(e);
        drive();
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        Hold = 1'b0;
        Team_Recall = '0;
        q.delete();
        drive();
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        cyc();
        while (!Dispatch_Valid && n < maxc) begin
            cyc();
            n++;
        end
        check("valid_timeout", 32'(Dispatch_Valid), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, vt[5], tm[5];
        // 1: reset and idle
        cyc();
        check("rst_outputs", {Serve, Dispatch_Valid, Dispatch_Zone, Dispatch_Team, Team_Busy, Dispatch_Count}, 32'd0);
        cyc();
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("idle_serve", 32'(Serve), 32'd0);
        end
        // 2: single dispatch, priority 2 -> 32-cycle mission
        push(8'h2A, 2'd2);
        cyc();
        check("t1_serve", 32'(Serve), 32'd1);
        cyc();
        check("t2_valid", 32'(Dispatch_Valid), 32'd1);
        check("t2_serve", 32'(Serve), 32'd0);
        check("t2_zone", 32'(Dispatch_Zone), 32'h2A);
        check("t2_team", 32'(Dispatch_Team), 32'd0);
        n = 0;
        while (Team_Busy[0] && n < 100) begin
            n++;
            cyc();
        end
        check("busy_len", 32'(n), 32'd32);
        // 3: five priority-0 entries
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(i + 1), 2'd0);
        for (int i = 0; i < 5; i++) begin
            wait_valid(40);
            vt[i] = cyc_n;
            tm[i] = int'(Dispatch_Team);
        end
        for (int i = 0; i < 4; i++) check("five_team", 32'(tm[i]), 32'(i));
        check("five_team4", 32'(tm[4]), 32'd0);
        for (int i = 1; i < 4; i++) check("five_gap", 32'(vt[i] - vt[i-1]), 32'd3);
        check("five_wait", 32'(vt[4] - vt[3]), 32'd9);
        // 4: recall frees team 1 while all busy
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 2'd3);
        for (int i = 0; i < 4; i++) wait_valid(20);
        cyc();
        cyc();
        check("all_busy", 32'(Team_Busy), 32'hF);
        Team_Recall = 4'b0010;
        cyc();
        Team_Recall = '0;
        check("recall_free", 32'(Team_Busy[1]), 32'd0);
        wait_valid(20);
        check("recall_team", 32'(Dispatch_Team), 32'd1);
        check("recall_zone", 32'(Dispatch_Zone), 32'h14);
        // 4b: recall in the load cycle loses to the load
        do_reset();
        push(8'h55, 2'd1);
        cyc();
        check("load_serve", 32'(Serve), 32'd1);
        Team_Recall = 4'b0001;
        cyc();
        Team_Recall = '0;
        check("load_wins", 32'(Team_Busy[0]), 32'd1);
        // 5: hold blocks serving
        do_reset();
        Hold = 1'b1;
        push(8'h77, 2'd0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_serve", 32'(Serve), 32'd0);
        end
        Hold = 1'b0;
        cyc();
        check("unhold_serve", 32'(Serve), 32'd1);
        // 6: reset during FETCH
        do_reset();
        push(8'h99, 2'd3);
        cyc();
        check("fetch_serve", 32'(Serve), 32'd1);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("abort_valid", 32'(Dispatch_Valid), 32'd0);
        check("abort_busy", 32'(Team_Busy), 32'd0);
        check("abort_count", 32'(Dispatch_Count), 32'd0);
        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if ($urandom_range(0, 2) == 0 && q.size() < 6) push(8'($urandom), 2'($urandom));
            Hold = $urandom_range(0, 9) == 0;
            Team_Recall = ($urandom_range(0, 19) == 0) ? NT'($urandom) : '0;
            Reset = $urandom_range(0, 499) == 0;
        end
        Reset = 1'b0;
        cyc();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
